mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares a single memory port between the core's instruction bus (ibus) and data bus (dbus).
- Serialises requests with one outstanding transaction at a time.
- Returns responses to the owning requester with a one-cycle data_ok pulse.
- Sits between the core and the memory/cache side; it is the only path to memory.

Parameters:
STARVE_LIMIT, 4, consecutive dbus grants while ibus is pending before ibus is forced to win
TIMEOUT, 255, max cycles in WAIT before abort with err_timeout; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
ireq_valid  in  1  ibus request
ireq_addr  in  64  ibus fetch address
iresp_addr_ok  out  1  ibus request accepted downstream
iresp_data_ok  out  1  ibus response pulse
iresp_data  out  32  fetched instruction
dreq_valid  in  1  dbus request
dreq_addr  in  64  dbus address
dreq_size  in  3  msize_t encoding
dreq_strobe  in  8  byte write enables; all zero means read
dreq_data  in  64  write data
dresp_addr_ok  out  1  dbus request accepted downstream
dresp_data_ok  out  1  dbus response pulse
dresp_data  out  64  read data
mreq_valid  out  1  downstream request
mreq_is_write  out  1  write transaction
mreq_addr  out  64  downstream address
mreq_size  out  3  downstream size
mreq_strobe  out  8  downstream strobes
mreq_data  out  64  downstream write data
mreq_ready  in  1  downstream accepts request this cycle
mresp_valid  in  1  downstream response valid
mresp_data  in  64  downstream read data
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (reset=0, async) forces all of the following:
  - FSM to IDLE; owner, starve counter and timeout counter to 0.
  - err_timeout to 0.
  - All outputs to 0.
- IDLE, arbitration when any valid is high:
  - If only one requester is valid, it wins.
  - If both are valid, dbus wins, unless starve_cnt == STARVE_LIMIT, in which case ibus wins.
  - The winner's fields are latched into the request registers and the FSM moves to REQ the next cycle. Grant latency from IDLE is 1 cycle.
- Starve counter:
  - Increments on each dbus grant made while ireq_valid=1.
  - Clears on any ibus grant, and whenever ireq_valid=0 at arbitration.
  - Saturates at STARVE_LIMIT.
- Request formation:
  - ibus: mreq_size=3'b010, strobe=0, is_write=0.
  - dbus: mreq_is_write = |dreq_strobe; size, strobe and data are passed through from the latched dbus fields.
- REQ:
  - mreq_valid=1 with the latched fields held stable.
  - When mreq_ready=1: the owner's *_addr_ok pulses for that same cycle, and the FSM moves to WAIT.
- WAIT:
  - mreq_valid=0; the timeout counter increments each cycle.
  - On mresp_valid=1, the response data is latched and the FSM moves to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without mresp_valid: err_timeout is set, the FSM moves to RESP, and zero data is returned.
  - A response arriving in the same cycle the counter reaches TIMEOUT counts as a success.
- RESP:
  - The owner's *_data_ok=1 for exactly 1 cycle, with data valid.
  - ibus data = latched word[63:32] if the latched addr[2]=1, else word[31:0].
  - dbus data = full 64-bit word.
  - Next state is IDLE, so back-to-back transactions are spaced by at least 1 idle cycle.
- Requester rules:
  - Requesters must hold valid and fields until data_ok.
  - If a requester drops valid mid-transaction, the transaction still completes and data_ok still pulses.
- Other conditions:
  - mresp_valid outside WAIT is ignored.
  - The non-owner's addr_ok and data_ok stay 0 at all times.
  - err_timeout is cleared only by reset.
  - busy = (state != IDLE).
  - Reset asserted mid-transaction abandons it; a later stray mresp_valid is ignored.

Test Plan:
- ibus only, addr=0x8000_0004, mreq_ready=1 immediately, mresp 2 cycles later with data 0x1111_2222_3333_4444 -> mreq size 2, iresp_data_ok 1-cycle pulse with iresp_data=0x1111_2222.
- ireq_valid and dreq_valid both high from IDLE, dreq store (strobe=0xFF, data=0xDEAD) -> dbus served first with mreq_is_write=1 and strobe 0xFF; ibus served next; dresp_data_ok precedes iresp_data_ok.
- dbus held continuously valid with ibus also valid, STARVE_LIMIT=4 -> exactly 4 dbus grants, then an ibus grant, then the counter resets.
- mreq_ready held low 5 cycles -> mreq_valid and fields stable all 5 cycles; addr_ok pulses only in the accept cycle.
- TIMEOUT=8 with no mresp_valid -> err_timeout=1 after 8 WAIT cycles; owner data_ok=1 with data 0; err_timeout stays 1 until reset.
- Reset asserted while in WAIT, then mresp_valid=1 after release -> FSM stays IDLE; no data_ok to either side; all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction bus and the data bus. It keeps a single
// transaction outstanding, gives dbus priority and lets ibus win after a run of dbus grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic        mreq_is_write,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mreq_ready,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
  localparam logic          TMO_EN     = (TIMEOUT != 0);
  localparam logic          OWN_I      = 1'b0;
  localparam logic          OWN_D      = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_r;
  logic            owner_r;
  logic [SW-1:0]   starve_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;

  logic            ibus_win_s;
  logic            accept_s;
  logic            tmo_hit_s;
  logic [TW-1:0]   tmo_next_s;
  logic [SW-1:0]   starve_inc_s;
  logic [63:0]     resp_word_s;

  // Arbitration decision, accept handshake and timeout detection.
  always_comb begin
    ibus_win_s    = 1'b0;
    iresp_addr_ok = 1'b0;
    dresp_addr_ok = 1'b0;
    if (ireq_valid && (!dreq_valid || (starve_cnt_r == STARVE_MAX))) begin
      ibus_win_s = 1'b1;
    end else begin
      ibus_win_s = 1'b0;
    end
    accept_s = (state_r == REQ) && mreq_ready;
    // addr_ok must pulse in the very cycle the downstream accepts, so it cannot be registered
    if (accept_s && (owner_r == OWN_I)) begin
      iresp_addr_ok = 1'b1;
    end else if (accept_s) begin
      dresp_addr_ok = 1'b1;
    end else begin
      iresp_addr_ok = 1'b0;
      dresp_addr_ok = 1'b0;
    end
    tmo_next_s   = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    tmo_hit_s    = TMO_EN && (tmo_next_s == TMO_MAX) && !mresp_valid;
    starve_inc_s = (starve_cnt_r == STARVE_MAX) ? starve_cnt_r
                                                : starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    resp_word_s  = mresp_valid ? mresp_data : 64'd0;
  end

  // Transaction FSM with all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      owner_r       <= OWN_I;
      starve_cnt_r  <= {SW{1'b0}};
      tmo_cnt_r     <= {TW{1'b0}};
      iresp_data_ok <= 1'b0;
      iresp_data    <= 32'd0;
      dresp_data_ok <= 1'b0;
      dresp_data    <= 64'd0;
      mreq_valid    <= 1'b0;
      mreq_is_write <= 1'b0;
      mreq_addr     <= 64'd0;
      mreq_size     <= 3'd0;
      mreq_strobe   <= 8'd0;
      mreq_data     <= 64'd0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ireq_valid || dreq_valid) begin
            state_r    <= REQ;
            busy       <= 1'b1;
            mreq_valid <= 1'b1;
            if (ibus_win_s) begin
              owner_r       <= OWN_I;
              starve_cnt_r  <= {SW{1'b0}};
              mreq_addr     <= ireq_addr;
              mreq_size     <= 3'b010;
              mreq_strobe   <= 8'h00;
              mreq_data     <= 64'd0;
              mreq_is_write <= 1'b0;
            end else begin
              owner_r       <= OWN_D;
              starve_cnt_r  <= ireq_valid ? starve_inc_s : {SW{1'b0}};
              mreq_addr     <= dreq_addr;
              mreq_size     <= dreq_size;
              mreq_strobe   <= dreq_strobe;
              mreq_data     <= dreq_data;
              mreq_is_write <= |dreq_strobe;
            end
          end
        end
        REQ: begin
          if (accept_s) begin
            state_r    <= WAIT;
            mreq_valid <= 1'b0;
            tmo_cnt_r  <= {TW{1'b0}};
          end
        end
        WAIT: begin
          tmo_cnt_r <= tmo_next_s;
          // a response landing on the limit cycle wins over the timeout
          if (mresp_valid || tmo_hit_s) begin
            state_r <= RESP;
            if (tmo_hit_s) begin
              err_timeout <= 1'b1;
            end
            if (owner_r == OWN_D) begin
              dresp_data_ok <= 1'b1;
              dresp_data    <= resp_word_s;
            end else begin
              iresp_data_ok <= 1'b1;
              iresp_data    <= mreq_addr[2] ? resp_word_s[63:32] : resp_word_s[31:0];
            end
          end
        end
        RESP: begin
          state_r       <= IDLE;
          busy          <= 1'b0;
          iresp_data_ok <= 1'b0;
          dresp_data_ok <= 1'b0;
          iresp_data    <= 32'd0;
          dresp_data    <= 64'd0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queue-driven requesters, a behavioural memory responder,
// and expected grants/data pushed at stimulus time and popped as the arbiter produces them.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid, mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mreq_ready, mresp_valid;
  logic [63:0] mresp_data;
  logic        busy, err_timeout;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mreq_ready(mreq_ready), .mresp_valid(mresp_valid), .mresp_data(mresp_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dreq_t;
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_WAIT} rsp_e;

  int          checks, failures, cyc, acc_cyc, dok_cyc;
  int          rdy_cnt, w_cnt, ready_delay, resp_delay;
  bit          rsp_en;
  rsp_e        rsp_st;
  logic [1:0]  cur_port;        // 0 none, 1 ibus, 2 dbus
  logic [63:0] i_pend[$], i_exp[$], d_exp[$];
  dreq_t       d_pend[$];
  logic [1:0]  ord_exp[$];
  logic [63:0] cap_addr, cap_data, last_idata;
  logic [12:0] cap_ctl;

  function automatic logic [63:0] word_of(input logic [63:0] a);
    return {a[31:0] ^ 32'h9111_2226, a[31:0] ^ 32'hB333_4440};
  endfunction

  function automatic logic any_out();
    return |{iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data,
             mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data, busy};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ibus_req(input logic [63:0] a, input bit ok);
    logic [63:0] w;
    w = word_of(a);
    i_pend.push_back(a);
    if (!ok) i_exp.push_back(64'd0);
    else if (a[2]) i_exp.push_back({32'd0, w[63:32]});
    else i_exp.push_back({32'd0, w[31:0]});
  endtask

  task automatic dbus_req(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                          input logic [63:0] dat, input bit ok);
    dreq_t r;
    r = '{addr: a, size: sz, strobe: st, data: dat};
    d_pend.push_back(r);
    d_exp.push_back(ok ? word_of(a) : 64'd0);
  endtask

  // One clock: score responses, drive requesters, then act as the memory.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (iresp_data_ok) begin
      check_eq("i_dok_owner", 64'(cur_port), 64'd1);
      if (i_exp.size() > 0) check_eq("i_data", 64'(iresp_data), i_exp.pop_front());
      else check_eq("i_exp_size", 64'(i_exp.size()), 64'd1);
      if (i_pend.size() > 0) void'(i_pend.pop_front());
      last_idata = 64'(iresp_data);
      cur_port = 2'd0; rsp_st = R_IDLE; dok_cyc = cyc;
    end
    if (dresp_data_ok) begin
      check_eq("d_dok_owner", 64'(cur_port), 64'd2);
      if (d_exp.size() > 0) check_eq("d_data", dresp_data, d_exp.pop_front());
      else check_eq("d_exp_size", 64'(d_exp.size()), 64'd1);
      if (d_pend.size() > 0) void'(d_pend.pop_front());
      cur_port = 2'd0; rsp_st = R_IDLE; dok_cyc = cyc;
    end
    ireq_valid = (i_pend.size() > 0);
    if (i_pend.size() > 0) ireq_addr = i_pend[0];
    dreq_valid = (d_pend.size() > 0);
    if (d_pend.size() > 0) begin
      dreq_addr = d_pend[0].addr; dreq_size = d_pend[0].size;
      dreq_strobe = d_pend[0].strobe; dreq_data = d_pend[0].data;
    end
    if (rsp_st == R_IDLE) begin
      mreq_ready = 1'b0; mresp_valid = 1'b0;
      if (mreq_valid) begin
        if (ord_exp.size() > 0) cur_port = ord_exp.pop_front();
        else begin
          check_eq("spurious_grant", 64'(ord_exp.size()), 64'd1);
          cur_port = 2'd0;
        end
        if (cur_port == 2'd1 && i_pend.size() > 0) begin
          check_eq("i_req_addr", mreq_addr, i_pend[0]);
          check_eq("i_req_ctl", 64'({mreq_size, mreq_strobe, mreq_is_write}), 64'({3'b010, 8'h00, 1'b0}));
        end else if (cur_port == 2'd2 && d_pend.size() > 0) begin
          check_eq("d_req_addr", mreq_addr, d_pend[0].addr);
          check_eq("d_req_ctl", 64'({mreq_size, mreq_strobe, mreq_is_write}),
                   64'({d_pend[0].size, d_pend[0].strobe, |d_pend[0].strobe}));
          check_eq("d_req_data", mreq_data, d_pend[0].data);
        end
        cap_addr = mreq_addr; cap_data = mreq_data;
        cap_ctl  = {mreq_valid, mreq_is_write, mreq_size, mreq_strobe};
        rdy_cnt  = ready_delay;
        rsp_st   = R_HOLD;
      end
    end
    if (rsp_st == R_HOLD) begin
      check_eq("hold_addr", mreq_addr, cap_addr);
      check_eq("hold_ctl", 64'({mreq_valid, mreq_is_write, mreq_size, mreq_strobe}), 64'(cap_ctl));
      check_eq("hold_data", mreq_data, cap_data);
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        mreq_ready = 1'b0;
        check_eq("addr_ok_early", 64'({iresp_addr_ok, dresp_addr_ok}), 64'd0);
      end else begin
        mreq_ready = 1'b1;
        #1;
        check_eq("addr_ok", 64'({iresp_addr_ok, dresp_addr_ok}), (cur_port == 2'd1) ? 64'd2 : 64'd1);
        acc_cyc = cyc; w_cnt = 0; rsp_st = R_WAIT;
      end
    end else if (rsp_st == R_WAIT) begin
      mreq_ready = 1'b0;
      w_cnt++;
      if (w_cnt == 1) check_eq("mreq_drop", 64'(mreq_valid), 64'd0);
      mresp_valid = rsp_en && (w_cnt == resp_delay);
      mresp_data  = mresp_valid ? word_of(cap_addr) : 64'd0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      if (ord_exp.size() == 0 && i_pend.size() == 0 && d_pend.size() == 0 &&
          cur_port == 2'd0 && !busy) done = 1'b1;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; acc_cyc = 0; dok_cyc = 0;
    rdy_cnt = 0; w_cnt = 0; ready_delay = 0; resp_delay = 1; rsp_en = 1'b1;
    rsp_st = R_IDLE; cur_port = 2'd0; last_idata = 64'd0;
    reset = 1'b0; ireq_valid = 1'b0; ireq_addr = 64'd0; dreq_valid = 1'b0; dreq_addr = 64'd0;
    dreq_size = 3'd0; dreq_strobe = 8'd0; dreq_data = 64'd0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_data = 64'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'(any_out()), 64'd0);
    check_eq("rst_err", 64'(err_timeout), 64'd0);
    reset = 1'b1;
    tick();

    // ibus fetch from the upper word
    resp_delay = 2;
    ord_exp.push_back(2'd1);
    ibus_req(64'h8000_0004, 1'b1);
    drain("t1_drain", 30);
    check_eq("t1_idata", last_idata, 64'h1111_2222);

    // simultaneous requests: dbus store goes first
    resp_delay = 1;
    ord_exp.push_back(2'd2); ord_exp.push_back(2'd1);
    dbus_req(64'h1000_0008, 3'd3, 8'hFF, 64'hDEAD, 1'b1);
    ibus_req(64'h8000_0010, 1'b1);
    drain("t2_drain", 40);

    // starvation: four dbus grants, then ibus, and the count starts over
    for (int k = 0; k < 9; k++) dbus_req(64'h2000_0000 + 64'(k * 8), 3'd3, 8'h00, 64'd0, 1'b1);
    ibus_req(64'h8000_0020, 1'b1);
    ibus_req(64'h8000_0024, 1'b1);
    for (int k = 0; k < 4; k++) ord_exp.push_back(2'd2);
    ord_exp.push_back(2'd1);
    for (int k = 0; k < 4; k++) ord_exp.push_back(2'd2);
    ord_exp.push_back(2'd1);
    ord_exp.push_back(2'd2);
    drain("t3_drain", 200);

    // downstream stalls for five cycles
    ready_delay = 5; resp_delay = 3;
    ord_exp.push_back(2'd2);
    dbus_req(64'h3000_0010, 3'd2, 8'h0F, 64'h1234_5678, 1'b1);
    drain("t4_drain", 40);
    ready_delay = 0;

    // response on the very cycle the counter reaches the limit still succeeds
    resp_delay = TIMEOUT;
    ord_exp.push_back(2'd2);
    dbus_req(64'h4000_0000, 3'd3, 8'h00, 64'd0, 1'b1);
    drain("t5b_drain", 40);
    check_eq("t5b_latency", 64'(dok_cyc - acc_cyc), 64'(TIMEOUT + 1));
    check_eq("t5b_err", 64'(err_timeout), 64'd0);

    // no response at all: abort with zero data and a sticky error
    rsp_en = 1'b0;
    ord_exp.push_back(2'd1);
    ibus_req(64'h8000_0004, 1'b0);
    drain("t5_drain", 40);
    check_eq("t5_latency", 64'(dok_cyc - acc_cyc), 64'(TIMEOUT + 1));
    check_eq("t5_err", 64'(err_timeout), 64'd1);
    rsp_en = 1'b1; resp_delay = 1;
    ord_exp.push_back(2'd2);
    dbus_req(64'h5000_0000, 3'd3, 8'h00, 64'd0, 1'b1);
    drain("t5c_drain", 30);
    check_eq("t5c_err_sticky", 64'(err_timeout), 64'd1);

    // reset while waiting, then a stray response
    rsp_en = 1'b0;
    ord_exp.push_back(2'd1);
    i_pend.push_back(64'h8000_0040);
    for (int n = 0; n < 20 && rsp_st != R_WAIT; n++) tick();
    check_eq("t6_reach_wait", 64'(rsp_st == R_WAIT), 64'd1);
    tick(); tick();
    check_eq("t6_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    i_pend.delete(); i_exp.delete(); ord_exp.delete();
    cur_port = 2'd0; rsp_st = R_IDLE; ireq_valid = 1'b0; mreq_ready = 1'b0;
    #1;
    check_eq("t6_rst_outs", 64'(any_out()), 64'd0);
    check_eq("t6_rst_err", 64'(err_timeout), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    mresp_valid = 1'b1; mresp_data = 64'hFFFF_0000_FFFF_0000;
    repeat (4) tick();
    check_eq("t6_idle_outs", 64'(any_out()), 64'd0);
    check_eq("t6_idle_err", 64'(err_timeout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
